chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle adder and the successor of the combinational full-adder cell.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, rippling the carry through a registered carry flop between chunks.
- Produces sum, carry-out and signed-overflow behind a valid/ready handshake on both sides.
- Used where area matters more than throughput, e.g. serial datapaths and accumulators.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle (1..WIDTH); NCHUNK = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands x, y, cin are presented
- in_ready  output  1  block can accept operands
- x  input  WIDTH  operand A, unsigned or two's complement
- y  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  result on s, c, ovf is valid
- out_ready  input  1  consumer takes the result
- s  output  WIDTH  sum, x+y+cin mod 2^WIDTH
- c  output  1  carry-out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock, one domain. Reset is asynchronous and active-low: clk and rst_n.
- FSM states: IDLE, CALC, DONE.
- On rst_n low (any time, including mid-CALC):
  - State goes to IDLE and the chunk index to 0.
  - s=0, c=0, ovf=0, out_valid=0, in_ready=1 (combinational from IDLE).
  - Any operation in flight is discarded.
- IDLE:
  - in_ready=1.
  - Accept occurs on an edge with in_valid=1.
  - At accept: latch x, y, cin into internal operand registers; set carry flop = cin; index = 0; go to CALC.
  - in_valid=0: stay in IDLE.
- CALC:
  - in_ready=0, out_valid=0.
  - Each cycle adds chunk[index] of the latched operands plus the carry flop.
  - At the edge: write the CHUNK-bit sum into the s register, update the carry flop, index+1.
  - On the edge where index=NCHUNK-1:
    - c = final carry.
    - ovf = carry into bit WIDTH-1 XOR final carry.
    - Go to DONE.
- DONE:
  - out_valid=1; s, c, ovf stable.
  - On an edge with out_ready=1: go to IDLE. out_valid drops the following cycle and in_ready rises.
  - out_ready=0: hold indefinitely.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge.
  - CHUNK=WIDTH gives 1 cycle.
  - Minimum initiation interval is NCHUNK+2 cycles with out_ready held high.
- in_valid and operand changes while not in IDLE are ignored; there is no queuing.
- out_ready while out_valid=0 is ignored.
- s, c, ovf keep the last result after leaving DONE until the next operation starts overwriting s. Consumers sample only while out_valid=1.
- s is written chunk by chunk during CALC, so intermediate values are visible and undefined for consumers.
- Widths:
  - Per-chunk add is CHUNK+1 bits wide; the MSB is the next carry.
  - No sign extension; unsigned and signed use the same sum.
  - ovf is meaningful only for signed interpretation.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Reset: assert rst_n=0 -> s=0x0000, c=0, ovf=0, out_valid=0, in_ready=1; release, idle 3 cycles -> no change.
- Basic add: x=0x1234, y=0x4321, cin=0 -> s=0x5555, c=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout.
- Full ripple: x=0xFFFF, y=0x0001, cin=0 -> s=0x0000, c=1, ovf=0.
- Overflow via cin: x=0x7FFF, y=0x0000, cin=1 -> s=0x8000, c=0, ovf=1. Also x=0x8000, y=0x8000, cin=0 -> s=0x0000, c=1, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and s/c/ovf stable.
  - Drive in_valid=1 with new operands -> ignored.
  - Pulse out_ready=1 -> IDLE next cycle; the new operands are then accepted; the result matches the new operands.
- Mid-operation reset plus parameter sweep:
  - Drop rst_n after 2 CALC cycles -> all outputs 0 immediately; reissue 0x00FF+0x0001 -> s=0x0100.
  - Repeat the basic add with CHUNK=1 (latency 16) and CHUNK=16 (latency 1).

Source files
------------

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle adder, CHUNK bits per clock with registered carry
// Produces x+y+cin, carry-out and signed overflow behind valid/ready handshakes.

module chunked_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                          state_q, state_d;
   logic [NCHUNK-1:0][CHUNK-1:0]    x_q, x_d;
   logic [NCHUNK-1:0][CHUNK-1:0]    y_q, y_d;
   logic [NCHUNK-1:0][CHUNK-1:0]    s_q, s_d;
   logic                            carry_q, carry_d;
   logic [IDXW-1:0]                 idx_q, idx_d;
   logic                            c_q, c_d;
   logic                            ovf_q, ovf_d;

   logic [CHUNK-1:0]                x_chunk, y_chunk;
   logic [CHUNK:0]                  chunk_sum;

   // The chunk MSB of the last chunk is the word MSB, so carry-into-MSB is recovered from sum bit.
   always_comb begin
      x_chunk   = x_q[idx_q];
      y_chunk   = y_q[idx_q];
      chunk_sum = {1'b0, x_chunk} + {1'b0, y_chunk} + {{CHUNK{1'b0}}, carry_q};
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      s_d     = s_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      c_d     = c_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = x;
               y_d     = y;
               carry_d = cin;
               idx_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            s_d[idx_q] = chunk_sum[CHUNK-1:0];
            carry_d    = chunk_sum[CHUNK];
            if (idx_q == LAST_IDX) begin
               c_d     = chunk_sum[CHUNK];
               ovf_d   = x_chunk[CHUNK-1] ^ y_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         c_q     <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign s         = s_q;
   assign c         = c_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb/tb_chunked_serial_adder.sv - randomized self-checking bench for chunked_serial_adder
// Three instances (CHUNK=4, 1, 16) share clock and reset and are exercised one at a time.

module tb_chunked_serial_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic [15:0] x         [3];
   logic [15:0] y         [3];
   logic        cin       [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [15:0] s         [3];
   logic        c         [3];
   logic        ovf       [3];

   int checks = 0;
   int errors = 0;
   int lat [3] = '{4, 16, 1};

   chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .x(x[0]), .y(y[0]), .cin(cin[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .s(s[0]), .c(c[0]), .ovf(ovf[0]));

   chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) dut_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .x(x[1]), .y(y[1]), .cin(cin[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .s(s[1]), .c(c[1]), .ovf(ovf[1]));

   chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut_c16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .x(x[2]), .y(y[2]), .cin(cin[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .s(s[2]), .c(c[2]), .ovf(ovf[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer sum; overflow when same-signed operands give a result of other sign.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic ci);
      logic [16:0] full;
      logic        v;
      full = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      v    = (a[15] == b[15]) && (full[15] != a[15]);
      return {v, full};
   endfunction

   task automatic check_result(input int k, input string tag, input logic [17:0] e);
      check({tag, ".s"},   {16'd0, s[k]},   {16'd0, e[15:0]});
      check({tag, ".c"},   {31'd0, c[k]},   {31'd0, e[16]});
      check({tag, ".ovf"}, {31'd0, ovf[k]}, {31'd0, e[17]});
   endtask

   task automatic start_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic ci);
      int n = 0;
      @(negedge clk);
      while (!in_ready[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("start_ready", {31'd0, in_ready[k]}, 32'd1);
      in_valid[k] = 1'b1;
      x[k] = a; y[k] = b; cin[k] = ci;
      @(posedge clk);
      #1 in_valid[k] = 1'b0;
   endtask

   // Called just after the accept edge; leaves time at a negedge with out_valid high.
   task automatic wait_result(input int k, input string tag, input logic [15:0] a,
                              input logic [15:0] b, input logic ci);
      int n = 0;
      bit done = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (out_valid[k]) done = 1;
         else check({tag, ".busy_in_ready"}, {31'd0, in_ready[k]}, 32'd0);
      end
      check({tag, ".latency"}, n, lat[k]);
      check_result(k, tag, model(a, b, ci));
   endtask

   task automatic drain(input int k, input string tag);
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1 out_ready[k] = 1'b0;
      @(negedge clk);
      check({tag, ".drain_out_valid"}, {31'd0, out_valid[k]}, 32'd0);
      check({tag, ".drain_in_ready"},  {31'd0, in_ready[k]},  32'd1);
   endtask

   task automatic do_op(input int k, input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic ci, input int hold);
      logic [17:0] e;
      start_op(k, a, b, ci);
      wait_result(k, tag, a, b, ci);
      e = model(a, b, ci);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, ".hold_valid"}, {31'd0, out_valid[k]}, 32'd1);
         check({tag, ".hold_s"}, {16'd0, s[k]}, {16'd0, e[15:0]});
      end
      drain(k, tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int k = 0; k < 3; k++) begin
         check({tag, ".s"},         {16'd0, s[k]},         32'd0);
         check({tag, ".c"},         {31'd0, c[k]},         32'd0);
         check({tag, ".ovf"},       {31'd0, ovf[k]},       32'd0);
         check({tag, ".out_valid"}, {31'd0, out_valid[k]}, 32'd0);
         check({tag, ".in_ready"},  {31'd0, in_ready[k]},  32'd1);
      end
   endtask

   initial begin
      logic [17:0] e_old;
      logic [15:0] ra, rb;
      logic        rc;

      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         x[k] = '0; y[k] = '0; cin[k] = 1'b0;
      end
      rst_n = 1'b0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_idle");

      do_op(0, "basic",     16'h1234, 16'h4321, 1'b0, 0);
      do_op(0, "ripple",    16'hFFFF, 16'h0001, 1'b0, 0);
      do_op(0, "ovf_cin",   16'h7FFF, 16'h0000, 1'b1, 0);
      do_op(0, "ovf_neg",   16'h8000, 16'h8000, 1'b0, 0);

      // Backpressure: result held while new operands are ignored, then accepted after release.
      start_op(0, 16'hA5A5, 16'h1111, 1'b1);
      wait_result(0, "bp_first", 16'hA5A5, 16'h1111, 1'b1);
      e_old = model(16'hA5A5, 16'h1111, 1'b1);
      in_valid[0] = 1'b1; x[0] = 16'h7000; y[0] = 16'h1000; cin[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp.out_valid", {31'd0, out_valid[0]}, 32'd1);
         check("bp.in_ready",  {31'd0, in_ready[0]},  32'd0);
         check_result(0, "bp.hold", e_old);
      end
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1 out_ready[0] = 1'b0;
      @(negedge clk);
      check("bp.idle_in_ready", {31'd0, in_ready[0]}, 32'd1);
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      wait_result(0, "bp_second", 16'h7000, 16'h1000, 1'b0);
      drain(0, "bp_second");

      // Asynchronous reset two cycles into CALC.
      start_op(0, 16'hFFFF, 16'hFFFF, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      do_op(0, "post_reset", 16'h00FF, 16'h0001, 1'b0, 0);

      do_op(1, "basic_c1",  16'h1234, 16'h4321, 1'b0, 0);
      do_op(2, "basic_c16", 16'h1234, 16'h4321, 1'b0, 0);
      do_op(1, "ripple_c1", 16'hFFFF, 16'h0001, 1'b0, 0);
      do_op(2, "ovf_c16",   16'h7FFF, 16'h0000, 1'b1, 0);

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            do_op(k, "rand", ra, rb, rc, int'($urandom_range(0, 3)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
